// File: rtl/tx_pkg.sv
// ============================================================================
// Module      : tx_pkg
// Description : Shared definitions for the UART transmit chain: FSM state
//               encodings, frame geometry and the default bit period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_pkg;

  // Transmitter FSM states; encodings are shared with the rest of the tx chain.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Data bits carried by one 8N1 frame.
  localparam int FRAME_BITS = 8;

  // Default clock cycles per serial bit (e.g. 50 MHz / 115200 baud).
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage : tx_pkg

`default_nettype wire

// File: rtl/tx_baud_tick.sv
// ============================================================================
// Module      : tx_baud_tick
// Description : Bit-period divider. Pulses tick on the last cycle of every
//               CLKS_PER_BIT-cycle bit period; restart re-aligns the period
//               to the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int                CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]     LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // Count 0..CLKS_PER_BIT-1, reloading to zero at each boundary or on restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule : tx_baud_tick

`default_nettype wire

// File: rtl/tx_uart_serialiser.sv
// ============================================================================
// Module      : tx_uart_serialiser
// Description : 8N1 UART transmitter. Accepts a byte on a tx_start pulse in
//               IDLE and shifts out start, 8 data bits (LSB first) and stop,
//               each held for CLKS_PER_BIT cycles. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_uart_serialiser
  import tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  tx_state_e             state;
  logic [FRAME_BITS-1:0] shreg;
  logic [2:0]            bit_idx;
  logic                  tick;
  logic                  accept;

  // A request is only honoured from IDLE (including the tx_done cycle).
  assign accept = (state == IDLE) && tx_start;

  tx_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (accept),
    .tick    (tick)
  );

  // Frame sequencer: state, shift register and registered line/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            state     <= START;
            shreg     <= tx_data;
            bit_idx   <= '0;
            tx_serial <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state     <= DATA;
            tx_serial <= shreg[0];
            shreg     <= {1'b0, shreg[FRAME_BITS-1:1]};
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'(FRAME_BITS - 1)) begin
              state     <= STOP;
              tx_serial <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_serial <= shreg[0];
              shreg     <= {1'b0, shreg[FRAME_BITS-1:1]};
            end
          end
        end
        STOP: begin
          if (tick) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : tx_uart_serialiser

`default_nettype wire

// File: tb/tb_tx_uart_serialiser.sv
// ============================================================================
// Module      : tb_tx_uart_serialiser
// Description : Directed + randomised bench for tx_uart_serialiser. Expected
//               line levels come from the frame {stop, data, start} built
//               from the byte, indexed by elapsed cycles / bit period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_uart_serialiser;

  localparam int CPB  = 4;
  localparam int CPB2 = 2;

  localparam int M_PLAIN    = 0;
  localparam int M_IGNORE   = 1;
  localparam int M_SCRAMBLE = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start, tx_start2;
  logic [7:0] tx_data, tx_data2;
  logic       tx_serial, tx_busy, tx_done;
  logic       tx_serial2, tx_busy2, tx_done2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tx_uart_serialiser #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  tx_uart_serialiser #(.CLKS_PER_BIT(CPB2)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .tx_start  (tx_start2),
    .tx_data   (tx_data2),
    .tx_serial (tx_serial2),
    .tx_busy   (tx_busy2),
    .tx_done   (tx_done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called one #1 after the accepting edge. Checks every cycle of the frame
  // and finishes at the falling edge of the tx_done cycle.
  task automatic check_frame(input logic [7:0] d, input int mode);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    for (int c = 1; c <= 10 * CPB; c++) begin
      if (mode == M_SCRAMBLE) tx_data = 8'($urandom);
      if (mode == M_IGNORE && c == 10) tx_data = 8'hFF;
      tx_start = (mode == M_IGNORE && c == 10);
      @(negedge clk);
      check($sformatf("serial d=%02h c=%0d", d, c), 32'(tx_serial), 32'(bits[(c - 1) / CPB]));
      check($sformatf("busy d=%02h c=%0d", d, c), 32'(tx_busy), 32'd1);
      if (tx_done !== 1'b0) check($sformatf("early_done c=%0d", c), 32'(tx_done), 32'd0);
      @(posedge clk); #1;
    end
    tx_start = 1'b0;
    @(negedge clk);
    check($sformatf("done d=%02h", d), 32'(tx_done), 32'd1);
    check($sformatf("busy_fall d=%02h", d), 32'(tx_busy), 32'd0);
    check($sformatf("idle_line d=%02h", d), 32'(tx_serial), 32'd1);
  endtask

  task automatic start_frame(input logic [7:0] d);
    tx_start = 1'b1;
    tx_data  = d;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check($sformatf("%s_busy%0d", tag, i), 32'(tx_busy), 32'd0);
      check($sformatf("%s_line%0d", tag, i), 32'(tx_serial), 32'd1);
      check($sformatf("%s_done%0d", tag, i), 32'(tx_done), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] nd;
    logic [19:0] bits2;

    reset     = 1'b0;
    tx_start  = 1'b0;
    tx_data   = 8'h00;
    tx_start2 = 1'b0;
    tx_data2  = 8'h00;

    // Reset state, with a request held high across an edge while in reset.
    repeat (2) @(posedge clk);
    #1 tx_start = 1'b1;
    tx_data = 8'hAA;
    @(negedge clk);
    check("rst_serial", 32'(tx_serial), 32'd1);
    check("rst_busy",   32'(tx_busy),   32'd0);
    check("rst_done",   32'(tx_done),   32'd0);
    @(posedge clk); #1;
    reset    = 1'b1;
    tx_start = 1'b0;
    check_idle("post_rst", 3);

    // Single A5 frame with exact bit timing.
    @(posedge clk); #1;
    start_frame(8'hA5);
    check_frame(8'hA5, M_PLAIN);
    @(posedge clk); #1;
    check_idle("after_a5", 2);

    // Mid-frame start with FF must be ignored and not queue a second frame.
    @(posedge clk); #1;
    start_frame(8'hA5);
    check_frame(8'hA5, M_IGNORE);
    @(posedge clk); #1;
    check_idle("no_queue", 3 * CPB);

    // Back-to-back: request during the tx_done cycle.
    @(posedge clk); #1;
    start_frame(8'hA5);
    check_frame(8'hA5, M_PLAIN);
    tx_start = 1'b1;
    tx_data  = 8'h3C;
    @(posedge clk); #1;
    tx_start = 1'b0;
    check_frame(8'h3C, M_PLAIN);
    @(posedge clk); #1;

    // Data stability: tx_data scrambled every cycle of an 81 frame.
    start_frame(8'h81);
    check_frame(8'h81, M_SCRAMBLE);
    @(posedge clk); #1;

    // Reset in DATA at cycle 17: line high, busy low at once, no tx_done.
    start_frame(8'($urandom));
    repeat (16) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    check("midrst_serial", 32'(tx_serial), 32'd1);
    check("midrst_busy",   32'(tx_busy),   32'd0);
    check("midrst_done",   32'(tx_done),   32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    check_idle("midrst_idle", 2 * CPB);
    @(posedge clk); #1;
    start_frame(8'h00);
    check_frame(8'h00, M_PLAIN);
    @(posedge clk); #1;

    // Randomised frames, some chained back-to-back.
    d = 8'($urandom);
    start_frame(d);
    for (int k = 0; k < 6; k++) begin
      check_frame(d, M_PLAIN);
      nd = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        tx_start = 1'b1;
        tx_data  = nd;
        @(posedge clk); #1;
        tx_start = 1'b0;
      end else begin
        @(posedge clk); #1;
        check_idle($sformatf("gap%0d", k), $urandom_range(1, 5));
        @(posedge clk); #1;
        start_frame(nd);
      end
      d = nd;
    end
    check_frame(d, M_PLAIN);
    @(posedge clk); #1;

    // Minimum divider: CLKS_PER_BIT=2, 55 frame over 20 cycles.
    bits2 = 20'h00000;
    begin
      logic [9:0] f;
      f = {1'b1, 8'h55, 1'b0};
      for (int b = 0; b < 10; b++) begin
        bits2[2 * b]     = f[b];
        bits2[2 * b + 1] = f[b];
      end
    end
    tx_start2 = 1'b1;
    tx_data2  = 8'h55;
    @(posedge clk); #1;
    tx_start2 = 1'b0;
    tx_data2  = 8'h00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("cpb2_serial c=%0d", c + 1), 32'(tx_serial2), 32'(bits2[c]));
      check($sformatf("cpb2_busy c=%0d", c + 1),   32'(tx_busy2),   32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("cpb2_done", 32'(tx_done2), 32'd1);
    check("cpb2_busy_fall", 32'(tx_busy2), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("cpb2_done_pulse", 32'(tx_done2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_tx_uart_serialiser

`default_nettype wire
